cpu_rf_write_arbiter: RTL and testbench
=======================================

Name: cpu_rf_write_arbiter

Overview:
- Owns the single register-file write port and shares it between two requesters:
  - the writeback pipeline stage, which uses the tag-change protocol and has no backpressure;
  - a long-latency unit (divider or load-miss path), which uses a valid/ready handshake.
- Keeps a 32-bit busy scoreboard of destinations still pending on the long-latency unit.
- Drives a stall request upstream so that the pipeline source never overflows the arbiter's one-entry holding register.

Parameters:
- TAG_W, 8, width of the pipeline tag. Must equal the core's tag width.
- STARVE_LIMIT, 4, number of consecutive lost arbitration cycles after which the long-latency unit is force-granted. Legal range 1..15.

Ports:
- i_clock  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_wb_tag  in  TAG_W  writeback tag; a change in value marks a new write event
- i_wb_inst_rd  in  5  writeback destination index
- i_wb_rd  in  32  writeback data
- o_stall  out  1  request to the writeback path to hold its tag
- i_lu_issue  in  1  long-latency op issued this cycle
- i_lu_issue_rd  in  5  destination index of the issued op
- i_lu_valid  in  1  long-latency result available
- o_lu_ready  out  1  long-latency result accepted this cycle
- i_lu_inst_rd  in  5  long-latency destination index
- i_lu_rd  in  32  long-latency data
- o_rf_write  out  1  register-file write strobe
- o_rf_idx  out  5  register-file write index
- o_rf_data  out  32  register-file write data
- o_busy  out  32  scoreboard; bit n set means rd n is pending on the long-latency unit

Behaviour:
- **Reset.** On a reset edge:
  - o_rf_write, o_rf_idx, o_rf_data, o_busy and o_stall are 0;
  - the internal last_tag is 0;
  - the holding register (pend) is empty;
  - the starve counter is 0.
  - A reset mid-operation discards pend and any unaccepted long-latency result. Upstream reset is concurrent.
- **New pipeline event.** Asserted when i_wb_tag differs from last_tag. last_tag updates to i_wb_tag on every non-reset edge where an event is detected.
- **Arbitration.** Evaluated each cycle in this priority order:
  1. If pend is valid and starve is not forced, pend is granted. A concurrent new event is captured into pend, and pend stays valid.
  2. Otherwise, if a new event is present and starve is not forced, the new event is granted.
  3. Otherwise, if i_lu_valid is high, the long-latency unit is granted and o_lu_ready=1.
- **Forced starvation grant.**
  - Starve is forced when the counter equals STARVE_LIMIT, i_lu_valid=1 and pend is empty.
  - In that case the long-latency unit is granted, and any concurrent new event is captured into pend.
- **Starve counter.**
  - Increments when i_lu_valid=1 and the long-latency unit is not granted. It saturates at STARVE_LIMIT.
  - Clears on a long-latency grant or when i_lu_valid=0.
- **o_lu_ready.** Combinational from the current registered state and the inputs. The long-latency source holds its data stable until it sees o_lu_ready=1.
- **o_stall.** Combinational from registered state: o_stall = pend valid. The upstream stage does not advance its tag in any cycle where o_stall=1.
- **Write output.**
  - Registered, with one-cycle latency: a grant at edge N drives o_rf_write=1 together with its idx/data during cycle N+1.
  - o_rf_write=0 in cycles with no grant.
  - Writes to idx 0 set o_rf_write=0 but still count as a consumed grant (pend drained, ready asserted).
- **Scoreboard.**
  - i_lu_issue sets o_busy[i_lu_issue_rd] at the next edge.
  - A long-latency grant clears o_busy[i_lu_inst_rd].
  - If both hit the same index in the same cycle, set wins.
  - Bit 0 is always 0.
- **Wrap-around.** Tag wrap-around needs no special handling: detection uses inequality only. A tag that returns to the same value on two consecutive samples is not a new event; upstream guarantees adjacent tags differ.

Test Plan:
1. Reset with i_wb_tag=0, then tag=1, rd=5, data=0xDEADBEEF → cycle after: o_rf_write=1, idx=5, data=0xDEADBEEF; the next cycle o_rf_write=0.
2. Same-cycle new tag (rd=3, 0x11) and i_lu_valid (rd=7, 0x22) → pipeline write of 3/0x11 first, o_lu_ready=0; the next cycle o_lu_ready=1 and the write is 7/0x22.
3. i_lu_valid held while tag changes every cycle, STARVE_LIMIT=4 → on the 5th cycle the long-latency unit is granted; the concurrent event goes to pend and o_stall=1 for one cycle; the pend write follows the long-latency write with no event lost or duplicated.
4. i_lu_issue rd=9 → o_busy=0x200; long-latency result rd=9 accepted → o_busy=0. Issue and accept of rd=12 in the same cycle → bit 12 stays set.
5. Tag change with rd=0, data=0xFFFFFFFF → o_rf_write stays 0; a following tag change with rd=1 writes normally.
6. Reset asserted while pend is valid and o_busy=0x0F0 → the next cycle o_stall=0, o_busy=0, o_rf_write=0, and the pend contents are never written.

Source files
------------

// File: rtl/cpu_rf_write_arbiter.sv
// Register-file write-port arbiter: shares one write port between the writeback
// stage (tag-change events, no backpressure) and a long-latency unit (valid/ready).
module cpu_rf_write_arbiter #(
  parameter int TAG_W        = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [TAG_W-1:0] i_wb_tag,
  input  logic [4:0]       i_wb_inst_rd,
  input  logic [31:0]      i_wb_rd,
  output logic             o_stall,
  input  logic             i_lu_issue,
  input  logic [4:0]       i_lu_issue_rd,
  input  logic             i_lu_valid,
  output logic             o_lu_ready,
  input  logic [4:0]       i_lu_inst_rd,
  input  logic [31:0]      i_lu_rd,
  output logic             o_rf_write,
  output logic [4:0]       o_rf_idx,
  output logic [31:0]      o_rf_data,
  output logic [31:0]      o_busy
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_PEND,
    GNT_WB,
    GNT_LU
  } grant_e;

  logic [TAG_W-1:0] last_tag_q, last_tag_d;
  logic             pend_valid_q, pend_valid_d;
  logic [4:0]       pend_idx_q, pend_idx_d;
  logic [31:0]      pend_data_q, pend_data_d;
  logic [3:0]       starve_q, starve_d;
  logic             rf_write_q, rf_write_d;
  logic [4:0]       rf_idx_q, rf_idx_d;
  logic [31:0]      rf_data_q, rf_data_d;
  logic [31:0]      busy_q, busy_d;

  logic             new_event;
  logic             starve_force;
  grant_e           grant;
  logic [4:0]       gnt_idx;
  logic [31:0]      gnt_data;

  assign new_event    = (i_wb_tag != last_tag_q);
  // Forcing only when pend is empty guarantees the pipeline never sees two
  // consecutive lost cycles, so the one-entry holding register cannot overflow.
  assign starve_force = (starve_q == STARVE_MAX) && i_lu_valid && !pend_valid_q;

  always_comb begin
    grant = GNT_NONE;
    if (pend_valid_q && !starve_force) begin
      grant = GNT_PEND;
    end else if (new_event && !starve_force) begin
      grant = GNT_WB;
    end else if (i_lu_valid) begin
      grant = GNT_LU;
    end
  end

  always_comb begin
    gnt_idx  = 5'd0;
    gnt_data = 32'd0;
    case (grant)
      GNT_PEND: begin
        gnt_idx  = pend_idx_q;
        gnt_data = pend_data_q;
      end
      GNT_WB: begin
        gnt_idx  = i_wb_inst_rd;
        gnt_data = i_wb_rd;
      end
      GNT_LU: begin
        gnt_idx  = i_lu_inst_rd;
        gnt_data = i_lu_rd;
      end
      default: begin
        gnt_idx  = 5'd0;
        gnt_data = 32'd0;
      end
    endcase
  end

  // Holding register: a new event that does not win this cycle is parked here.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_idx_d   = pend_idx_q;
    pend_data_d  = pend_data_q;
    if (new_event && (grant != GNT_WB)) begin
      pend_valid_d = 1'b1;
      pend_idx_d   = i_wb_inst_rd;
      pend_data_d  = i_wb_rd;
    end else if (grant == GNT_PEND) begin
      pend_valid_d = 1'b0;
    end
  end

  always_comb begin
    last_tag_d = last_tag_q;
    if (new_event) begin
      last_tag_d = i_wb_tag;
    end
  end

  always_comb begin
    starve_d = 4'd0;
    if (i_lu_valid && (grant != GNT_LU)) begin
      starve_d = (starve_q >= STARVE_MAX) ? STARVE_MAX : starve_q + 4'd1;
    end
  end

  // Index 0 is hardwired: the grant is consumed but no strobe is issued.
  always_comb begin
    rf_write_d = 1'b0;
    rf_idx_d   = rf_idx_q;
    rf_data_d  = rf_data_q;
    if (grant != GNT_NONE) begin
      rf_write_d = (gnt_idx != 5'd0);
      rf_idx_d   = gnt_idx;
      rf_data_d  = gnt_data;
    end
  end

  // Set after clear so an issue and a retire to the same rd leave the bit set.
  always_comb begin
    busy_d = busy_q;
    if (grant == GNT_LU) begin
      busy_d[i_lu_inst_rd] = 1'b0;
    end
    if (i_lu_issue) begin
      busy_d[i_lu_issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      last_tag_q   <= '0;
      pend_valid_q <= 1'b0;
      pend_idx_q   <= 5'd0;
      pend_data_q  <= 32'd0;
      starve_q     <= 4'd0;
      rf_write_q   <= 1'b0;
      rf_idx_q     <= 5'd0;
      rf_data_q    <= 32'd0;
      busy_q       <= 32'd0;
    end else begin
      last_tag_q   <= last_tag_d;
      pend_valid_q <= pend_valid_d;
      pend_idx_q   <= pend_idx_d;
      pend_data_q  <= pend_data_d;
      starve_q     <= starve_d;
      rf_write_q   <= rf_write_d;
      rf_idx_q     <= rf_idx_d;
      rf_data_q    <= rf_data_d;
      busy_q       <= busy_d;
    end
  end

  // Handshake: the long-latency result transfers on any edge where
  // i_lu_valid and o_lu_ready are both high; the source holds data until then.
  assign o_lu_ready = (grant == GNT_LU);
  assign o_stall    = pend_valid_q;
  assign o_rf_write = rf_write_q;
  assign o_rf_idx   = rf_idx_q;
  assign o_rf_data  = rf_data_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_cpu_rf_write_arbiter.sv
// Directed bench for cpu_rf_write_arbiter: a queue-based reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_cpu_rf_write_arbiter;

  localparam int TAG_W        = 8;
  localparam int STARVE_LIMIT = 4;

  logic             i_clock;
  logic             i_reset;
  logic [TAG_W-1:0] i_wb_tag;
  logic [4:0]       i_wb_inst_rd;
  logic [31:0]      i_wb_rd;
  logic             o_stall;
  logic             i_lu_issue;
  logic [4:0]       i_lu_issue_rd;
  logic             i_lu_valid;
  logic             o_lu_ready;
  logic [4:0]       i_lu_inst_rd;
  logic [31:0]      i_lu_rd;
  logic             o_rf_write;
  logic [4:0]       o_rf_idx;
  logic [31:0]      o_rf_data;
  logic [31:0]      o_busy;

  cpu_rf_write_arbiter #(
    .TAG_W        (TAG_W),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_wb_tag      (i_wb_tag),
    .i_wb_inst_rd  (i_wb_inst_rd),
    .i_wb_rd       (i_wb_rd),
    .o_stall       (o_stall),
    .i_lu_issue    (i_lu_issue),
    .i_lu_issue_rd (i_lu_issue_rd),
    .i_lu_valid    (i_lu_valid),
    .o_lu_ready    (o_lu_ready),
    .i_lu_inst_rd  (i_lu_inst_rd),
    .i_lu_rd       (i_lu_rd),
    .o_rf_write    (o_rf_write),
    .o_rf_idx      (o_rf_idx),
    .o_rf_data     (o_rf_data),
    .o_busy        (o_busy)
  );

  // ---------------- clock / reset ----------------
  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard counters ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Every pipeline event enters a FIFO; each cycle serves either the long-latency
  // unit or the FIFO head. A non-empty FIFO between edges is the holding register.
  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } wr_t;

  wr_t              m_fifo[$];
  logic [TAG_W-1:0] m_last_tag;
  int               m_starve;
  logic [31:0]      m_busy;
  logic             m_write;
  logic [4:0]       m_idx;
  logic [31:0]      m_data;
  bit               m_live = 0;

  function automatic bit lu_wins();
    bit evt;
    evt = (i_wb_tag != m_last_tag);
    if (i_lu_valid && m_starve >= STARVE_LIMIT && m_fifo.size() == 0) return 1'b1;
    if (m_fifo.size() != 0 || evt) return 1'b0;
    return i_lu_valid;
  endfunction

  always @(posedge i_clock) begin : model
    wr_t served;
    bit  have;
    bit  lu;
    if (i_reset) begin
      m_fifo.delete();
      m_last_tag = '0;
      m_starve   = 0;
      m_busy     = 32'd0;
      m_write    = 1'b0;
      m_idx      = 5'd0;
      m_data     = 32'd0;
      m_live     = 1;
    end else if (m_live) begin
      lu   = lu_wins();
      have = 1'b0;
      served = '0;
      if (i_wb_tag != m_last_tag) begin
        m_fifo.push_back({i_wb_inst_rd, i_wb_rd});
        m_last_tag = i_wb_tag;
      end
      if (lu) begin
        served = {i_lu_inst_rd, i_lu_rd};
        have   = 1'b1;
      end else if (m_fifo.size() != 0) begin
        served = m_fifo.pop_front();
        have   = 1'b1;
      end
      m_write = have && (served.idx != 5'd0);
      m_idx   = served.idx;
      m_data  = served.data;
      if (i_lu_valid && !lu) m_starve = (m_starve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_starve + 1;
      else m_starve = 0;
      if (lu) m_busy[i_lu_inst_rd] = 1'b0;
      if (i_lu_issue) m_busy[i_lu_issue_rd] = 1'b1;
      m_busy[0] = 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge i_clock) begin
    if (m_live) begin
      check("m_stall", 32'(o_stall), 32'(m_fifo.size() != 0));
      check("m_lu_ready", 32'(o_lu_ready), 32'(lu_wins()));
      check("m_rf_write", 32'(o_rf_write), 32'(m_write));
      if (m_write) begin
        check("m_rf_idx", 32'(o_rf_idx), 32'(m_idx));
        check("m_rf_data", o_rf_data, m_data);
      end
      check("m_busy", o_busy, m_busy);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge i_clock);
    #1;
  endtask

  task automatic sample();
    @(negedge i_clock);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    i_reset       = 1'b1;
    i_wb_tag      = '0;
    i_wb_inst_rd  = 5'd0;
    i_wb_rd       = 32'd0;
    i_lu_issue    = 1'b0;
    i_lu_issue_rd = 5'd0;
    i_lu_valid    = 1'b0;
    i_lu_inst_rd  = 5'd0;
    i_lu_rd       = 32'd0;
    repeat (2) cyc();
    i_reset = 1'b0;
    sample();
    check("reset_write", 32'(o_rf_write), 32'd0);
    check("reset_busy", o_busy, 32'd0);
    check("reset_stall", 32'(o_stall), 32'd0);

    // 1: single pipeline write
    cyc();
    i_wb_tag = 8'd1; i_wb_inst_rd = 5'd5; i_wb_rd = 32'hDEADBEEF;
    cyc();
    sample();
    check("t1_write", 32'(o_rf_write), 32'd1);
    check("t1_idx", 32'(o_rf_idx), 32'd5);
    check("t1_data", o_rf_data, 32'hDEADBEEF);
    cyc();
    sample();
    check("t1_idle", 32'(o_rf_write), 32'd0);

    // 2: same-cycle event and long-latency result
    cyc();
    i_wb_tag = 8'd2; i_wb_inst_rd = 5'd3; i_wb_rd = 32'h11;
    i_lu_valid = 1'b1; i_lu_inst_rd = 5'd7; i_lu_rd = 32'h22;
    sample();
    check("t2_ready0", 32'(o_lu_ready), 32'd0);
    cyc();
    sample();
    check("t2_wb_idx", 32'(o_rf_idx), 32'd3);
    check("t2_wb_data", o_rf_data, 32'h11);
    check("t2_ready1", 32'(o_lu_ready), 32'd1);
    cyc();
    i_lu_valid = 1'b0;
    sample();
    check("t2_lu_write", 32'(o_rf_write), 32'd1);
    check("t2_lu_idx", 32'(o_rf_idx), 32'd7);
    check("t2_lu_data", o_rf_data, 32'h22);

    // 3: starvation forcing with events every cycle
    cyc();
    i_lu_valid = 1'b1; i_lu_inst_rd = 5'd10; i_lu_rd = 32'hAA;
    for (int k = 1; k <= 5; k++) begin
      i_wb_tag = 8'(2 + k); i_wb_inst_rd = 5'(16 + k); i_wb_rd = 32'(k * 32'h100);
      sample();
      if (k == 4) check("t3_ready_c4", 32'(o_lu_ready), 32'd0);
      if (k == 5) check("t3_ready_c5", 32'(o_lu_ready), 32'd1);
      cyc();
    end
    i_lu_valid = 1'b0;
    sample();
    check("t3_stall", 32'(o_stall), 32'd1);
    check("t3_lu_idx", 32'(o_rf_idx), 32'd10);
    check("t3_lu_data", o_rf_data, 32'hAA);
    cyc();
    sample();
    check("t3_stall_clr", 32'(o_stall), 32'd0);
    check("t3_pend_write", 32'(o_rf_write), 32'd1);
    check("t3_pend_idx", 32'(o_rf_idx), 32'd21);
    check("t3_pend_data", o_rf_data, 32'h500);

    // 4: scoreboard set/clear and set-wins
    cyc();
    i_lu_issue = 1'b1; i_lu_issue_rd = 5'd9;
    cyc();
    i_lu_issue = 1'b0;
    sample();
    check("t4_busy9", o_busy, 32'h200);
    cyc();
    i_lu_valid = 1'b1; i_lu_inst_rd = 5'd9; i_lu_rd = 32'h99;
    cyc();
    i_lu_valid = 1'b0;
    sample();
    check("t4_busy_clr", o_busy, 32'd0);
    i_lu_issue = 1'b1; i_lu_issue_rd = 5'd12;
    cyc();
    i_lu_valid = 1'b1; i_lu_inst_rd = 5'd12; i_lu_rd = 32'h12;
    cyc();
    i_lu_issue = 1'b0; i_lu_valid = 1'b0;
    sample();
    check("t4_set_wins", o_busy, 32'h1000);
    i_lu_valid = 1'b1;
    cyc();
    i_lu_valid = 1'b0;
    sample();
    check("t4_busy12_clr", o_busy, 32'd0);

    // 5: writes to index 0 are suppressed
    cyc();
    i_wb_tag = 8'd8; i_wb_inst_rd = 5'd0; i_wb_rd = 32'hFFFFFFFF;
    cyc();
    sample();
    check("t5_rd0_write", 32'(o_rf_write), 32'd0);
    i_wb_tag = 8'd9; i_wb_inst_rd = 5'd1; i_wb_rd = 32'h1234;
    cyc();
    sample();
    check("t5_rd1_write", 32'(o_rf_write), 32'd1);
    check("t5_rd1_data", o_rf_data, 32'h1234);
    i_lu_valid = 1'b1; i_lu_inst_rd = 5'd0; i_lu_rd = 32'h55;
    sample();
    check("t5_lu_rd0_ready", 32'(o_lu_ready), 32'd1);
    cyc();
    i_lu_valid = 1'b0;
    sample();
    check("t5_lu_rd0_write", 32'(o_rf_write), 32'd0);

    // 6: reset while pend is valid and busy bits are set
    for (int i = 4; i < 8; i++) begin
      cyc();
      i_lu_issue = 1'b1; i_lu_issue_rd = 5'(i);
    end
    cyc();
    i_lu_issue = 1'b0;
    i_lu_valid = 1'b1; i_lu_inst_rd = 5'd0; i_lu_rd = 32'h77;
    for (int k = 0; k < 5; k++) begin
      i_wb_tag = 8'(10 + k); i_wb_inst_rd = 5'(24 + k); i_wb_rd = 32'hC0DE0000 + 32'(k);
      cyc();
    end
    i_lu_valid = 1'b0;
    i_reset    = 1'b1;
    i_wb_tag   = '0;
    sample();
    check("t6_pre_stall", 32'(o_stall), 32'd1);
    check("t6_pre_busy", o_busy, 32'h0F0);
    cyc();
    i_reset = 1'b0;
    sample();
    check("t6_stall", 32'(o_stall), 32'd0);
    check("t6_busy", o_busy, 32'd0);
    check("t6_write", 32'(o_rf_write), 32'd0);
    cyc();
    sample();
    check("t6_no_pend_write", 32'(o_rf_write), 32'd0);
    cyc();
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
